// File: rtl/exec_ctrl_if.sv
// Instruction handshake and register-file port bundle for exec_ctrl.
// The slave side belongs to the controller; the master side issues instructions and hosts the register file.
interface exec_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [2:0]  dst;
    logic [2:0]  src0;
    logic [2:0]  src1;
    logic [2:0]  rd0_addr;
    logic [2:0]  rd1_addr;
    logic [15:0] rd0_data;
    logic [15:0] rd1_data;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        done;

    modport slave (
        input  instr_valid, opcode, dst, src0, src1, rd0_data, rd1_data,
        output instr_ready, rd0_addr, rd1_addr, wr_en, wr_addr, wr_data, done
    );

    modport master (
        output instr_valid, opcode, dst, src0, src1, rd0_data, rd1_data,
        input  instr_ready, rd0_addr, rd1_addr, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/exec_ctrl.sv
// Single-issue execute controller: read operands, run ALU op or 16-step shift-add multiply,
// then write the result back to an external register file.
module exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    exec_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  dst_q, dst_d;
    logic [2:0]  src0_q, src0_d;
    logic [2:0]  src1_q, src1_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        alu_res = a_q;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHL:  alu_res = a_q << b_q[3:0];
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    op_d    = bus.opcode;
                    dst_d   = bus.dst;
                    src0_d  = bus.src0;
                    src1_d  = bus.src1;
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = bus.rd0_data;
                b_d     = bus.rd1_data;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (op_q == OP_MUL) ? MUL : EXEC;
            end
            EXEC: begin
                wr_data_d = alu_res;
                wr_addr_d = dst_q;
                state_d   = WB;
            end
            MUL: begin
                // A shifts left and B shifts right so B[0] always selects the next partial product
                acc_d = acc_q + (b_q[0] ? a_q : 16'h0000);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    wr_data_d = acc_d;
                    wr_addr_d = dst_q;
                    state_d   = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.rd0_addr    = src0_q;
    assign bus.rd1_addr    = src1_q;
    assign bus.wr_en       = (state_q == WB);
    assign bus.done        = (state_q == WB);
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
endmodule
